// File: rtl/vend_if.sv
// Handshake bundle between the vending transaction controller and its keypad/dispenser side.
interface vend_if #(parameter int CREDIT_W = 8);
   logic [9:0]          key_value;
   logic                dispense_ack;
   logic                dispense_req;
   logic [4:0]          product_sel;
   logic [CREDIT_W-1:0] credit;
   logic [CREDIT_W-1:0] change;
   logic                change_valid;
   logic                err;
   logic                fault;
   logic                busy;

   modport master (
      output key_value, dispense_ack,
      input  dispense_req, product_sel, credit, change, change_valid, err, fault, busy
   );

   modport slave (
      input  key_value, dispense_ack,
      output dispense_req, product_sel, credit, change, change_valid, err, fault, busy
   );
endinterface

// File: rtl/vend_ctrl.sv
// Vending transaction controller: key press detection, coin credit, product selection,
// dispenser request/acknowledge with timeout, and one-cycle change/refund result.
module vend_ctrl #(
   parameter int COIN_A       = 5,
   parameter int COIN_B       = 10,
   parameter int COIN_C       = 20,
   parameter int PRICE0       = 15,
   parameter int PRICE1       = 25,
   parameter int PRICE2       = 30,
   parameter int PRICE3       = 45,
   parameter int PRICE4       = 60,
   parameter int CREDIT_W     = 8,
   parameter int MAX_CREDIT   = 200,
   parameter int DISP_TIMEOUT = 1000
) (
   input logic   clk,
   input logic   reset,
   vend_if.slave bus
);

   localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

   state_t              state, state_nx;
   logic [9:0]          prev_key;
   logic [CREDIT_W-1:0] credit_q, credit_nx;
   logic [4:0]          sel_q, sel_nx;
   logic [CREDIT_W-1:0] change_q, change_nx;
   logic                err_q, err_nx;
   logic                fault_q, fault_nx;
   logic [CNT_W-1:0]    cnt_q, cnt_nx;

   logic [9:0]          key;
   logic                key_event, multi_key, is_coin, is_prod, is_confirm;
   logic [CREDIT_W-1:0] coin_val, price_val;
   logic [CREDIT_W:0]   sum;
   logic                fits;

   assign key        = bus.key_value;
   assign key_event  = (key != '0) && (prev_key == '0);
   assign multi_key  = !$onehot(key);
   assign is_coin    = |key[3:1];
   assign is_prod    = |key[8:4];
   assign is_confirm = key[0];

   // product_sel bit 4 is P0, bit 0 is P4, mirroring key_value[8:4]
   assign coin_val  = ({CREDIT_W{key[1]}} & CREDIT_W'(COIN_A))
                    | ({CREDIT_W{key[2]}} & CREDIT_W'(COIN_B))
                    | ({CREDIT_W{key[3]}} & CREDIT_W'(COIN_C));
   assign price_val = ({CREDIT_W{sel_q[4]}} & CREDIT_W'(PRICE0))
                    | ({CREDIT_W{sel_q[3]}} & CREDIT_W'(PRICE1))
                    | ({CREDIT_W{sel_q[2]}} & CREDIT_W'(PRICE2))
                    | ({CREDIT_W{sel_q[1]}} & CREDIT_W'(PRICE3))
                    | ({CREDIT_W{sel_q[0]}} & CREDIT_W'(PRICE4));

   assign sum  = {1'b0, credit_q} + {1'b0, coin_val};
   assign fits = sum <= (CREDIT_W+1)'(MAX_CREDIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         prev_key <= '0;
         credit_q <= '0;
         sel_q    <= '0;
         change_q <= '0;
         err_q    <= 1'b0;
         fault_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state    <= state_nx;
         prev_key <= key;
         credit_q <= credit_nx;
         sel_q    <= sel_nx;
         change_q <= change_nx;
         err_q    <= err_nx;
         fault_q  <= fault_nx;
         cnt_q    <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      credit_nx = credit_q;
      sel_nx    = sel_q;
      change_nx = change_q;
      err_nx    = 1'b0;
      fault_nx  = 1'b0;
      cnt_nx    = cnt_q;
      case (state)
         S_IDLE: begin
            if (key_event) begin
               if (multi_key) begin
                  err_nx = 1'b1;
               end else if (is_coin) begin
                  credit_nx = coin_val;
                  state_nx  = S_CREDIT;
               end else if (is_prod) begin
                  sel_nx = key[8:4];
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         S_CREDIT: begin
            if (key_event) begin
               if (multi_key) begin
                  err_nx = 1'b1;
               end else if (is_coin) begin
                  if (fits) credit_nx = sum[CREDIT_W-1:0];
                  else      err_nx    = 1'b1;
               end else if (is_prod) begin
                  sel_nx = key[8:4];
               end else if (is_confirm) begin
                  if (sel_q != '0 && credit_q >= price_val) begin
                     state_nx = S_DISPENSE;
                     cnt_nx   = '0;
                  end else begin
                     err_nx = 1'b1;
                  end
               end else begin
                  change_nx = credit_q;
                  credit_nx = '0;
                  state_nx  = S_CHANGE;
               end
            end
         end
         // An ack arriving on the timeout cycle is treated as a normal completion
         S_DISPENSE: begin
            if (bus.dispense_ack) begin
               change_nx = credit_q - price_val;
               credit_nx = '0;
               state_nx  = S_CHANGE;
            end else if (cnt_q == CNT_W'(DISP_TIMEOUT - 1)) begin
               fault_nx  = 1'b1;
               change_nx = credit_q;
               credit_nx = '0;
               state_nx  = S_CHANGE;
            end else begin
               cnt_nx = cnt_q + 1'b1;
            end
         end
         S_CHANGE: begin
            state_nx  = S_IDLE;
            sel_nx    = '0;
            change_nx = '0;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.dispense_req = (state == S_DISPENSE);
   assign bus.change_valid = (state == S_CHANGE);
   assign bus.busy         = (state == S_DISPENSE) || (state == S_CHANGE);
   assign bus.product_sel  = sel_q;
   assign bus.credit       = credit_q;
   assign bus.change       = change_q;
   assign bus.err          = err_q;
   assign bus.fault        = fault_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a transaction-level model checked every cycle,
// plus literal expectations at key points of directed purchase/refund/timeout scenarios.
module tb_vend_ctrl;

   localparam int M_IDLE   = 0;
   localparam int M_PAY    = 1;
   localparam int M_DISP   = 2;
   localparam int M_REFUND = 3;
   localparam int TIMEOUT  = 1000;
   localparam int MAXC     = 200;

   logic clk;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;
   bit   model_ok   = 0;

   int         prices [5] = '{15, 25, 30, 45, 60};
   int         m_mode, m_credit, m_sel, m_change, m_wait;
   bit         m_err, m_fault;
   logic [9:0] m_prev;

   vend_if #(.CREDIT_W(8)) bus ();

   vend_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int coin_of(input logic [9:0] k);
      if (k[1]) return 5;
      if (k[2]) return 10;
      return 20;
   endfunction

   // Transaction-level view of one clock edge, in terms of credit, selection and waiting time
   task automatic modelStep(input logic [9:0] k, input logic a, input logic r);
      bit ev;
      if (!r) begin
         m_mode = M_IDLE; m_prev = '0; m_credit = 0; m_sel = -1;
         m_change = 0; m_err = 0; m_fault = 0; m_wait = 0;
         model_ok = 1;
         return;
      end
      ev = (k != '0) && (m_prev == '0);
      m_prev  = k;
      m_err   = 0;
      m_fault = 0;
      if (m_mode == M_DISP) begin
         m_wait++;
         if (a) begin
            m_change = m_credit - prices[m_sel]; m_credit = 0; m_mode = M_REFUND;
         end else if (m_wait >= TIMEOUT) begin
            m_fault = 1; m_change = m_credit; m_credit = 0; m_mode = M_REFUND;
         end
      end else if (m_mode == M_REFUND) begin
         m_mode = M_IDLE; m_sel = -1; m_change = 0;
      end else if (ev) begin
         if ($countones(k) != 1) m_err = 1;
         else if (k[3:1] != '0) begin
            if (m_mode == M_IDLE) begin
               m_credit = coin_of(k); m_mode = M_PAY;
            end else if (m_credit + coin_of(k) <= MAXC) m_credit += coin_of(k);
            else m_err = 1;
         end else if (k[8:4] != '0) begin
            for (int n = 0; n < 5; n++) if (k[8-n]) m_sel = n;
         end else if (m_mode == M_IDLE) m_err = 1;
         else if (k[0]) begin
            if (m_sel >= 0 && m_credit >= prices[m_sel]) begin
               m_mode = M_DISP; m_wait = 0;
            end else m_err = 1;
         end else begin
            m_change = m_credit; m_credit = 0; m_mode = M_REFUND;
         end
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         checkOutput("credit",       int'(bus.credit),       m_credit);
         checkOutput("product_sel",  int'(bus.product_sel),  (m_sel < 0) ? 0 : (1 << (4 - m_sel)));
         checkOutput("change",       int'(bus.change),       m_change);
         checkOutput("change_valid", int'(bus.change_valid), int'(m_mode == M_REFUND));
         checkOutput("dispense_req", int'(bus.dispense_req), int'(m_mode == M_DISP));
         checkOutput("busy",         int'(bus.busy),         int'(m_mode == M_DISP || m_mode == M_REFUND));
         checkOutput("err",          int'(bus.err),          int'(m_err));
         checkOutput("fault",        int'(bus.fault),        int'(m_fault));
      end
   end

   task automatic applyStimulus(input logic [9:0] k, input logic a, input logic r, input int n);
      for (int i = 0; i < n; i++) begin
         bus.key_value    = k;
         bus.dispense_ack = a;
         reset            = r;
         @(posedge clk);
         modelStep(k, a, r);
         @(negedge clk);
      end
   endtask

   task automatic press(input logic [9:0] k);
      applyStimulus(k, 1'b0, 1'b1, 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
   endtask

   initial begin
      bus.key_value    = '0;
      bus.dispense_ack = 1'b0;
      reset            = 1'b0;
      @(negedge clk);
      applyStimulus(10'h000, 1'b0, 1'b0, 2);
      checkOutput("lit_reset_credit", int'(bus.credit), 0);
      checkOutput("lit_reset_req",    int'(bus.dispense_req), 0);
      checkOutput("lit_reset_busy",   int'(bus.busy), 0);

      // held coin gives one event; too little credit for P0 is rejected, then topped up
      applyStimulus(10'h004, 1'b0, 1'b1, 5);
      checkOutput("lit_held_coin", int'(bus.credit), 10);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      press(10'h100);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      checkOutput("lit_short_err", int'(bus.err), 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      press(10'h002);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      checkOutput("lit_disp_req", int'(bus.dispense_req), 1);
      checkOutput("lit_disp_sel", int'(bus.product_sel), 'h10);
      applyStimulus(10'h000, 1'b0, 1'b1, 2);
      applyStimulus(10'h000, 1'b1, 1'b1, 1);
      checkOutput("lit_exact_cv",     int'(bus.change_valid), 1);
      checkOutput("lit_exact_change", int'(bus.change), 0);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);

      // purchase with change: 10+10+20 for P0 leaves 25
      press(10'h004); press(10'h004); press(10'h008); press(10'h100);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 2);
      applyStimulus(10'h000, 1'b1, 1'b1, 1);
      checkOutput("lit_change_25", int'(bus.change), 25);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      applyStimulus(10'h000, 1'b1, 1'b1, 1);

      // unaffordable P4 then cancel refunds the credit
      press(10'h004); press(10'h010);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      checkOutput("lit_p4_err",    int'(bus.err), 1);
      checkOutput("lit_p4_credit", int'(bus.credit), 10);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      applyStimulus(10'h200, 1'b0, 1'b1, 1);
      checkOutput("lit_cancel_change", int'(bus.change), 10);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      checkOutput("lit_cancel_credit", int'(bus.credit), 0);

      // credit ceiling
      for (int i = 0; i < 10; i++) press(10'h008);
      checkOutput("lit_max_credit", int'(bus.credit), 200);
      applyStimulus(10'h008, 1'b0, 1'b1, 1);
      checkOutput("lit_over_err",    int'(bus.err), 1);
      checkOutput("lit_over_credit", int'(bus.credit), 200);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      applyStimulus(10'h00C, 1'b0, 1'b1, 1);
      checkOutput("lit_multi_err", int'(bus.err), 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);

      // timeout: entry edge, then 1000th edge in dispense refunds everything
      press(10'h100);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      applyStimulus(10'h200, 1'b0, 1'b1, 1);
      checkOutput("lit_disp_cancel_err",  int'(bus.err), 0);
      checkOutput("lit_disp_cancel_busy", int'(bus.busy), 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 997);
      checkOutput("lit_pre_timeout_req", int'(bus.dispense_req), 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);
      checkOutput("lit_timeout_fault",  int'(bus.fault), 1);
      checkOutput("lit_timeout_req",    int'(bus.dispense_req), 0);
      checkOutput("lit_timeout_change", int'(bus.change), 200);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);

      // ack on the timeout edge completes normally
      press(10'h008); press(10'h100);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 999);
      applyStimulus(10'h000, 1'b1, 1'b1, 1);
      checkOutput("lit_race_fault",  int'(bus.fault), 0);
      checkOutput("lit_race_change", int'(bus.change), 5);
      applyStimulus(10'h000, 1'b0, 1'b1, 1);

      // reset mid-dispense; a reset glitch between edges is not seen
      press(10'h008); press(10'h100);
      applyStimulus(10'h001, 1'b0, 1'b1, 1);
      applyStimulus(10'h000, 1'b0, 1'b1, 2);
      bus.key_value = '0; bus.dispense_ack = 1'b0; reset = 1'b1;
      @(posedge clk);
      modelStep(10'h000, 1'b0, 1'b1);
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      checkOutput("lit_glitch_req", int'(bus.dispense_req), 1);
      applyStimulus(10'h000, 1'b0, 1'b0, 1);
      checkOutput("lit_rst_req",    int'(bus.dispense_req), 0);
      checkOutput("lit_rst_credit", int'(bus.credit), 0);
      checkOutput("lit_rst_sel",    int'(bus.product_sel), 0);
      applyStimulus(10'h000, 1'b0, 1'b1, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
